// File: rtl/riscv_program_loader.sv
// rtl/riscv_program_loader.sv - boot loader and instruction memory for the single-cycle RISC-V core.
// Optional trailing checksum word enabled by defining LOADER_CHECKSUM_EN.
module riscv_program_loader #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic [31:0] pc_current,
  output logic [31:0] instr,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  localparam int AW = $clog2(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {CLEAR, WAIT_HDR, LOAD, CHECK, RUN, ERROR} state_t;
`else
  typedef enum logic [2:0] {CLEAR, WAIT_HDR, LOAD, RUN, ERROR} state_t;
`endif

  state_t        state, state_n;
  logic [AW-1:0] clear_idx;
  logic [AW:0]   wl;
  logic [AW:0]   n_words;
  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem [0:DEPTH-1];
  logic          unused_pc;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   sum;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_n = state;
    case (state)
      CLEAR:
        if (clear_idx == AW'(DEPTH - 1)) state_n = WAIT_HDR;
      WAIT_HDR:
        if (accept) begin
          if (in_data == 32'd0 || in_data > 32'(DEPTH)) state_n = ERROR;
          else                                          state_n = LOAD;
        end
      LOAD:
        if (accept && ((wl + 1'b1) == n_words)) begin
`ifdef LOADER_CHECKSUM_EN
          state_n = CHECK;
`else
          state_n = RUN;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
      CHECK:
        if (accept) state_n = (in_data == sum) ? RUN : ERROR;
`endif
      RUN:     state_n = RUN;
      ERROR:   state_n = ERROR;
      default: state_n = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
      wl        <= '0;
      n_words   <= '0;
      in_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state     <= state_n;
`ifdef LOADER_CHECKSUM_EN
      in_ready  <= (state_n == WAIT_HDR) || (state_n == LOAD) || (state_n == CHECK);
`else
      in_ready  <= (state_n == WAIT_HDR) || (state_n == LOAD);
`endif
      cpu_reset <= (state_n != RUN);
      done      <= (state_n == RUN);
      error     <= (state_n == ERROR);
      if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
      if (state == WAIT_HDR && accept) begin
        n_words <= in_data[AW:0];
        wl      <= '0;
      end
      // wl stops at N because LOAD is left on the N-th word
      if (state == LOAD && accept) wl <= wl + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (state == CLEAR && state_n == WAIT_HDR) sum <= '0;
      if (state == LOAD && accept) sum <= sum + in_data;
`endif
    end
  end

  // Single write port shared by the NOP fill and the payload load
  assign mem_we    = !reset && ((state == CLEAR) || (state == LOAD && accept));
  assign mem_waddr = (state == CLEAR) ? clear_idx : wl[AW-1:0];
  assign mem_wdata = (state == CLEAR) ? NOP_WORD : in_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instr        = mem[pc_current[AW+1:2]];
  assign words_loaded = 9'(wl);
  assign unused_pc    = ^{pc_current[31:AW+2], pc_current[1:0]};

endmodule

// File: tb/tb_riscv_program_loader.sv
// tb/tb_riscv_program_loader.sv - directed self-checking bench for riscv_program_loader.
module tb_riscv_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] pc_current = '0;
  logic [31:0] instr;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0] prog [0:14] = '{
    32'h000AB0B7, 32'hFFFCD137, 32'h00001237, 32'h00001197, 32'h00A00293,
    32'h00500313, 32'h006283B3, 32'h40628433, 32'h0062F4B3, 32'h0062E533,
    32'h00729593, 32'h0012D613, 32'h00B52023, 32'h00052683, 32'h0000006F
  };

  riscv_program_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pc_current(pc_current), .instr(instr),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (in_ready) break;
    end
  endtask

  task automatic send_word(input logic [31:0] d, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = d;
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    bit bad;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 9'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b cpu_reset=%b done=%b error=%b wl=%0d, need 0 1 0 0 0",
               in_ready, cpu_reset, done, error, words_loaded);
    end
    reset = 1'b0;
    wait_ready(cyc);
    checks++;
    if (cyc != 256) begin
      errors++;
      $display("FAIL clear_duration: in_ready rose after %0d edges, need 256", cyc);
    end
    repeat (44) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL wait_hdr_idle: ready=%b cpu_reset=%b, need 1 1", in_ready, cpu_reset);
    end
    bad = 1'b0;
    foreach (prog[i]) begin end
    for (int p = 0; p < 256; p++) begin
      pc_current = 32'(p * 4); #1;
      if (instr !== NOP) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clear_fill: some entry is not %h", NOP);
    end
    pc_current = 32'h3FC; #1;
    checks++;
    if (instr !== NOP) begin
      errors++;
      $display("FAIL pc_3fc: instr=%h, need %h", instr, NOP);
    end
    pc_current = 32'h400; #1;
    checks++;
    if (instr !== NOP) begin
      errors++;
      $display("FAIL pc_400_wrap: instr=%h, need %h", instr, NOP);
    end
  endtask

  task automatic test_program_15();
    int cyc;
    bit ok;
    apply_reset();
    wait_ready(cyc);
    send_word(32'd15, ok);
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL pre_last_word: cpu_reset=%b done=%b, need 1 0", cpu_reset, done);
        end
      end
      send_word(prog[i], ok);
      if (!ok) break;
    end
    checks++;
    if (!ok || cpu_reset !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load15_run: ok=%b cpu_reset=%b done=%b ready=%b, need 1 0 1 0", ok, cpu_reset, done, in_ready);
    end
    idle();
    checks++;
    if (words_loaded !== 9'd15) begin
      errors++;
      $display("FAIL load15_count: words_loaded=%0d, need 15", words_loaded);
    end
    pc_current = 32'h0; #1;
    checks++;
    if (instr !== 32'h000AB0B7) begin
      errors++;
      $display("FAIL load15_pc0: instr=%h, need 000ab0b7", instr);
    end
    pc_current = 32'h4; #1;
    checks++;
    if (instr !== 32'hFFFCD137) begin
      errors++;
      $display("FAIL load15_pc4: instr=%h, need fffcd137", instr);
    end
    pc_current = 32'h38; #1;
    checks++;
    if (instr !== 32'h0000006F) begin
      errors++;
      $display("FAIL load15_pc38: instr=%h, need 0000006f", instr);
    end
    pc_current = 32'h3C; #1;
    checks++;
    if (instr !== NOP) begin
      errors++;
      $display("FAIL load15_pc3c: instr=%h, need %h", instr, NOP);
    end
  endtask

  task automatic test_bad_header(input logic [31:0] hdr);
    int cyc;
    bit ok;
    bit leak;
    apply_reset();
    wait_ready(cyc);
    send_word(hdr, ok);
    checks++;
    if (!ok || error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_hdr_%0d: ok=%b error=%b cpu_reset=%b ready=%b done=%b, need 1 1 1 0 0",
               hdr, ok, error, cpu_reset, in_ready, done);
    end
    leak = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hDEAD0000 + 32'(i);
      if (in_ready !== 1'b0 || error !== 1'b1) leak = 1'b1;
    end
    idle();
    pc_current = 32'h0; #1;
    checks++;
    if (leak || words_loaded !== 9'd0 || instr !== NOP) begin
      errors++;
      $display("FAIL bad_hdr_%0d_sticky: leak=%b wl=%0d instr=%h, need 0 0 %h", hdr, leak, words_loaded, instr, NOP);
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    bit ok;
    bit bad;
    apply_reset();
    wait_ready(cyc);
    send_word(32'd10, ok);
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(1) == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
      end
      send_word(32'hA0000000 + 32'(i), ok);
    end
    idle();
    checks++;
    if (words_loaded !== 9'd5 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL partial_load: wl=%0d cpu_reset=%b, need 5 1", words_loaded, cpu_reset);
    end
    apply_reset();
    wait_ready(cyc);
    bad = 1'b0;
    for (int p = 0; p < 256; p++) begin
      pc_current = 32'(p * 4); #1;
      if (instr !== NOP) bad = 1'b1;
    end
    checks++;
    if (bad || cyc != 256) begin
      errors++;
      $display("FAIL refill_after_reset: stale=%b clear_edges=%0d, need 0 256", bad, cyc);
    end
    send_word(32'd10, ok);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(1) == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
      end
      send_word(32'hB0000000 + 32'(i), ok);
    end
    idle();
    checks++;
    if (words_loaded !== 9'd10 || done !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL fresh_load10: wl=%0d done=%b cpu_reset=%b, need 10 1 0", words_loaded, done, cpu_reset);
    end
    bad = 1'b0;
    for (int p = 0; p < 10; p++) begin
      pc_current = 32'(p * 4); #1;
      if (instr !== 32'hB0000000 + 32'(p)) bad = 1'b1;
    end
    pc_current = 32'd40; #1;
    if (instr !== NOP) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fresh_load10_contents: entries 0..10 differ from b0000000+i / %h", NOP);
    end
  endtask

  task automatic test_run_frozen();
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hC0DE0000 + 32'(i);
      if (in_ready !== 1'b0 || done !== 1'b1) bad = 1'b1;
    end
    idle();
    for (int p = 0; p < 10; p++) begin
      pc_current = 32'(p * 4); #1;
      if (instr !== 32'hB0000000 + 32'(p)) bad = 1'b1;
    end
    checks++;
    if (bad || words_loaded !== 9'd10) begin
      errors++;
      $display("FAIL run_frozen: disturbed=%b wl=%0d, need 0 10", bad, words_loaded);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input int n,
                               input logic [31:0] csum, input bit expect_ok);
    int cyc;
    bit ok;
    logic [31:0] w [0:2];
    w[0] = w0; w[1] = w1; w[2] = w2;
    apply_reset();
    wait_ready(cyc);
    send_word(32'(n), ok);
    for (int i = 0; i < n; i++) send_word(w[i], ok);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL csum_check_state: done=%b ready=%b, need 0 1", done, in_ready);
    end
    send_word(csum, ok);
    idle();
    checks++;
    if (done !== expect_ok || error !== !expect_ok || cpu_reset !== !expect_ok) begin
      errors++;
      $display("FAIL csum_%h: done=%b error=%b cpu_reset=%b, need %b %b %b",
               csum, done, error, cpu_reset, expect_ok, !expect_ok, !expect_ok);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program_15();
    test_bad_header(32'd0);
    test_bad_header(32'd257);
    test_reset_mid_load();
    test_run_frozen();
`ifdef LOADER_CHECKSUM_EN
    test_checksum(32'd1, 32'd2, 32'd3, 3, 32'h00000006, 1'b1);
    test_checksum(32'd1, 32'd2, 32'd3, 3, 32'h00000007, 1'b0);
    test_checksum(32'hFFFFFFFF, 32'd2, 32'd0, 2, 32'h00000001, 1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
